// File: rtl/alu_driver_if.sv
// alu_driver_if: command, ALU-port and response signals of the ALU command driver.
interface alu_driver_if #(
    parameter int DATA_W = 12,
    parameter int INST_W = 3
);
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [DATA_W-1:0] i_cmd_a;
    logic [DATA_W-1:0] i_cmd_b;
    logic [INST_W-1:0] i_cmd_inst;
    logic              o_alu_valid;
    logic [DATA_W-1:0] o_alu_data_a;
    logic [DATA_W-1:0] o_alu_data_b;
    logic [INST_W-1:0] o_alu_inst;
    logic              i_alu_valid;
    logic [DATA_W-1:0] i_alu_data;
    logic              i_alu_overflow;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [DATA_W-1:0] o_rsp_data;
    logic              o_rsp_overflow;
    logic              o_rsp_timeout;
    logic              o_busy;
    logic [7:0]        o_ovf_count;

    modport master (
        input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_inst,
        input  i_alu_valid, i_alu_data, i_alu_overflow, i_rsp_ready,
        output o_cmd_ready, o_alu_valid, o_alu_data_a, o_alu_data_b, o_alu_inst,
        output o_rsp_valid, o_rsp_data, o_rsp_overflow, o_rsp_timeout, o_busy, o_ovf_count
    );

    modport slave (
        output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_inst,
        output i_alu_valid, i_alu_data, i_alu_overflow, i_rsp_ready,
        input  o_cmd_ready, o_alu_valid, o_alu_data_a, o_alu_data_b, o_alu_inst,
        input  o_rsp_valid, o_rsp_data, o_rsp_overflow, o_rsp_timeout, o_busy, o_ovf_count
    );
endinterface

// File: rtl/alu_driver.sv
// alu_driver: issues one command at a time to the ALU, waits for its response
// (or a timeout) and buffers results in a small FIFO for the downstream consumer.
module alu_driver #(
    parameter int DATA_W     = 12,
    parameter int INST_W     = 3,
    parameter int TIMEOUT    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input logic i_clk,
    input logic i_rst_n,
    alu_driver_if.master bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q, state_d;
    logic              rdy_en_q;
    logic              alu_valid_q, alu_valid_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [7:0]        ovf_cnt_q, ovf_cnt_d;
    logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
    logic              mem_ovf  [FIFO_DEPTH];
    logic              mem_to   [FIFO_DEPTH];
    logic              accept, push, pop, push_ovf, push_to, not_empty, expire;
    logic [DATA_W-1:0] push_data;

    assign not_empty = cnt_q != '0;
    assign expire    = timer_q == TW'(TIMEOUT - 1);
    // rdy_en_q keeps ready low until the first edge after reset release
    assign bus.o_cmd_ready = state_q == IDLE && rdy_en_q && cnt_q < (AW+1)'(FIFO_DEPTH);
    assign accept    = bus.i_cmd_valid && bus.o_cmd_ready;
    assign pop       = bus.i_rsp_ready && not_empty;

    always_comb begin
        state_d     = state_q;
        alu_valid_d = 1'b0;
        a_d         = a_q;
        b_d         = b_q;
        inst_d      = inst_q;
        timer_d     = timer_q;
        push        = 1'b0;
        push_data   = '0;
        push_ovf    = 1'b0;
        push_to     = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                a_d         = bus.i_cmd_a;
                b_d         = bus.i_cmd_b;
                inst_d      = bus.i_cmd_inst;
                alu_valid_d = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: if (bus.i_alu_valid) begin
                push      = 1'b1;
                push_data = bus.i_alu_data;
                push_ovf  = bus.i_alu_overflow;
                state_d   = IDLE;
            end else if (expire) begin
                push    = 1'b1;
                push_to = 1'b1;
                state_d = IDLE;
            end else begin
                timer_d = timer_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        wr_d      = push ? wr_q + 1'b1 : wr_q;
        rd_d      = pop ? rd_q + 1'b1 : rd_q;
        cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_cnt_d = (push && push_ovf && ovf_cnt_q != 8'hFF) ? ovf_cnt_q + 8'd1 : ovf_cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            rdy_en_q    <= 1'b0;
            alu_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            inst_q      <= '0;
            timer_q     <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            ovf_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rdy_en_q    <= 1'b1;
            alu_valid_q <= alu_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            inst_q      <= inst_d;
            timer_q     <= timer_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    // storage needs no reset: the head is masked whenever the FIFO is empty
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_data[wr_q] <= push_data;
            mem_ovf[wr_q]  <= push_ovf;
            mem_to[wr_q]   <= push_to;
        end
    end

    assign bus.o_alu_valid    = alu_valid_q;
    assign bus.o_alu_data_a   = a_q;
    assign bus.o_alu_data_b   = b_q;
    assign bus.o_alu_inst     = inst_q;
    assign bus.o_rsp_valid    = not_empty;
    assign bus.o_rsp_data     = not_empty ? mem_data[rd_q] : '0;
    assign bus.o_rsp_overflow = not_empty && mem_ovf[rd_q];
    assign bus.o_rsp_timeout  = not_empty && mem_to[rd_q];
    assign bus.o_busy         = state_q != IDLE;
    assign bus.o_ovf_count    = ovf_cnt_q;
endmodule

// File: tb/tb_alu_driver.sv
// tb_alu_driver: directed vectors and corner-case sequences for alu_driver with a
// registered ADD/SUB ALU stand-in that can be muted to force timeouts.
module tb_alu_driver;
    localparam int DW = 12;
    localparam int IW = 3;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [IW-1:0] inst;
        logic [DW-1:0] d;
        logic          o;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic alu_mute = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   n;
    int   p0;
    vec_t v [6];

    always #5 clk = ~clk;

    alu_driver_if #(.DATA_W(DW), .INST_W(IW)) bus ();

    alu_driver #(.DATA_W(DW), .INST_W(IW), .TIMEOUT(4), .FIFO_DEPTH(4)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    function automatic logic [DW:0] alu_f(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [IW-1:0] inst);
        logic [DW-1:0] s;
        logic          o;
        s = (inst == 3'd1) ? a - b : a + b;
        o = (inst == 3'd1) ? (a[DW-1] != b[DW-1] && s[DW-1] != a[DW-1])
                           : (a[DW-1] == b[DW-1] && s[DW-1] != a[DW-1]);
        return {o, s};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.i_alu_valid    <= 1'b0;
            bus.i_alu_data     <= '0;
            bus.i_alu_overflow <= 1'b0;
        end else begin
            bus.i_alu_valid                       <= bus.o_alu_valid && !alu_mute;
            {bus.i_alu_overflow, bus.i_alu_data}  <= alu_f(bus.o_alu_data_a, bus.o_alu_data_b, bus.o_alu_inst);
        end
    end

    always @(negedge clk) if (bus.o_alu_valid) pulses++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [IW-1:0] inst);
        int k = 0;
        @(negedge clk);
        bus.i_cmd_a = a;
        bus.i_cmd_b = b;
        bus.i_cmd_inst = inst;
        bus.i_cmd_valid = 1'b1;
        while (!bus.o_cmd_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("cmd_ready_wait", int'(bus.o_cmd_ready), 1);
        @(posedge clk);
        #1 bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!bus.o_rsp_valid && lat < 20);
    endtask

    task automatic pop();
        @(negedge clk);
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.i_rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        v[0] = '{12'h005, 12'h003, 3'd0, 12'h008, 1'b0};
        v[1] = '{12'h7FF, 12'h001, 3'd0, 12'h800, 1'b1};
        v[2] = '{12'h800, 12'h001, 3'd1, 12'h7FF, 1'b1};
        v[3] = '{12'hFFF, 12'hFFF, 3'd0, 12'hFFE, 1'b0};
        v[4] = '{12'h005, 12'h003, 3'd1, 12'h002, 1'b0};
        v[5] = '{12'h800, 12'h800, 3'd0, 12'h000, 1'b1};
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_a = '0;
        bus.i_cmd_b = '0;
        bus.i_cmd_inst = '0;
        bus.i_rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", int'(bus.o_cmd_ready), 0);
        chk("rst_alu_valid", int'(bus.o_alu_valid), 0);
        chk("rst_rsp_valid", int'(bus.o_rsp_valid), 0);
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_ovf_count", int'(bus.o_ovf_count), 0);
        chk("rst_rsp_data", int'(bus.o_rsp_data), 0);
        chk("rst_alu_a", int'(bus.o_alu_data_a), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_release", int'(bus.o_cmd_ready), 1);

        for (int i = 0; i < 6; i++) begin
            p0 = pulses;
            send(v[i].a, v[i].b, v[i].inst);
            chk($sformatf("v%0d_issue_valid", i), int'(bus.o_alu_valid), 1);
            chk($sformatf("v%0d_issue_a", i), int'(bus.o_alu_data_a), int'(v[i].a));
            chk($sformatf("v%0d_busy", i), int'(bus.o_busy), 1);
            wait_rsp(n);
            chk($sformatf("v%0d_latency", i), n, 2);
            chk($sformatf("v%0d_data", i), int'(bus.o_rsp_data), int'(v[i].d));
            chk($sformatf("v%0d_ovf", i), int'(bus.o_rsp_overflow), int'(v[i].o));
            chk($sformatf("v%0d_to", i), int'(bus.o_rsp_timeout), 0);
            chk($sformatf("v%0d_pulses", i), pulses - p0, 1);
            pop();
            chk($sformatf("v%0d_popped", i), int'(bus.o_rsp_valid), 0);
        end
        chk("ovf_count_table", int'(bus.o_ovf_count), 3);

        alu_mute = 1'b1;
        send(12'h7FF, 12'h001, 3'd0);
        wait_rsp(n);
        chk("to_latency", n, 5);
        chk("to_data", int'(bus.o_rsp_data), 0);
        chk("to_ovf", int'(bus.o_rsp_overflow), 0);
        chk("to_flag", int'(bus.o_rsp_timeout), 1);
        chk("to_ovf_count", int'(bus.o_ovf_count), 3);
        pop();
        alu_mute = 1'b0;
        send(12'h001, 12'h002, 3'd0);
        wait_rsp(n);
        chk("after_to_latency", n, 2);
        chk("after_to_data", int'(bus.o_rsp_data), 3);
        chk("after_to_flag", int'(bus.o_rsp_timeout), 0);
        pop();

        for (int k = 1; k <= 4; k++) send(DW'(k * 16), 12'h000, 3'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.i_cmd_a = 12'd80;
        bus.i_cmd_b = 12'd0;
        bus.i_cmd_inst = 3'd0;
        bus.i_cmd_valid = 1'b1;
        chk("bp_busy", int'(bus.o_busy), 0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_full", int'(bus.o_cmd_ready), 0);
        end
        chk("bp_head0", int'(bus.o_rsp_data), 16);
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.i_rsp_ready = 1'b0;
        @(posedge clk);
        #1 bus.i_cmd_valid = 1'b0;
        chk("bp_fifth_accepted", int'(bus.o_busy), 1);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("bp_valid%0d", k), int'(bus.o_rsp_valid), 1);
            chk($sformatf("bp_data%0d", k), int'(bus.o_rsp_data), k * 16);
            pop();
        end
        chk("bp_empty", int'(bus.o_rsp_valid), 0);

        send(12'd100, 12'd0, 3'd0);
        wait_rsp(n);
        send(12'd200, 12'd0, 3'd0);
        @(posedge clk);
        @(negedge clk);
        bus.i_rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.i_rsp_ready = 1'b0;
        chk("pp_valid", int'(bus.o_rsp_valid), 1);
        chk("pp_head", int'(bus.o_rsp_data), 200);
        pop();
        chk("pp_count_one", int'(bus.o_rsp_valid), 0);

        bus.i_rsp_ready = 1'b1;
        repeat (300) send(12'h7FF, 12'h001, 3'd0);
        repeat (4) @(posedge clk);
        #1 chk("ovf_saturate", int'(bus.o_ovf_count), 255);
        bus.i_rsp_ready = 1'b0;

        send(12'h001, 12'h001, 3'd0);
        repeat (2) @(posedge clk);
        #1 chk("mid_pre_valid", int'(bus.o_rsp_valid), 1);
        alu_mute = 1'b1;
        send(12'h002, 12'h002, 3'd0);
        repeat (2) @(posedge clk);
        #2 chk("mid_busy_wait", int'(bus.o_busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_alu_valid", int'(bus.o_alu_valid), 0);
        chk("mid_rsp_valid", int'(bus.o_rsp_valid), 0);
        chk("mid_busy", int'(bus.o_busy), 0);
        chk("mid_ovf_count", int'(bus.o_ovf_count), 0);
        chk("mid_cmd_ready", int'(bus.o_cmd_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(12'h003, 12'h003, 3'd0);
        rst_n = 1'b0;
        #1 chk("issue_rst_alu_valid", int'(bus.o_alu_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_mute = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_no_stale", int'(bus.o_rsp_valid), 0);
        chk("post_rst_idle", int'(bus.o_busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
